// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufq.sv
// gf180mcu_fd_sc_mcu7t5v0__bufq: clocked elastic buffer, WIDTH bits by DEPTH words.
// Valid/ready handshake on both sides, first-word-fall-through read port.
//
// Ports:
//   CLK      clock, rising edge
//   RST      asynchronous active-high reset
//   I        write data            I_VALID  write request     I_READY  can accept (registered)
//   FLUSH    synchronous discard of all stored words
//   Z        head-of-queue data    Z_VALID  Z holds a word    Z_READY  consumer accepts Z
//   LEVEL    number of stored words, 0..DEPTH
module gf180mcu_fd_sc_mcu7t5v0__bufq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned LW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic             FLUSH,
   output logic [WIDTH-1:0] Z,
   output logic             Z_VALID,
   input  logic             Z_READY,
   output logic [LW-1:0]    LEVEL
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
   logic [LW-1:0]    r_level;
   logic             r_ready;

   logic             w_push, w_pop, w_zvalid;
   logic [PW-1:0]    w_rd_ptr_d, w_wr_ptr_d;
   logic [PW-1:0]    w_rd_inc, w_wr_inc;
   logic [LW-1:0]    w_level_d;
   logic             w_ready_d;

   assign w_zvalid = (r_level != '0);
   assign w_push   = I_VALID & r_ready;
   assign w_pop    = w_zvalid & Z_READY;

   // Explicit wrap compare so non-power-of-two depths work.
   assign w_rd_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
   assign w_wr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

   always_comb begin
      w_rd_ptr_d = r_rd_ptr;
      w_wr_ptr_d = r_wr_ptr;
      w_level_d  = r_level;
      if (FLUSH) begin
         w_rd_ptr_d = '0;
         w_wr_ptr_d = '0;
         w_level_d  = '0;
      end else begin
         if (w_push) w_wr_ptr_d = w_wr_inc;
         if (w_pop)  w_rd_ptr_d = w_rd_inc;
         unique case ({w_push, w_pop})
            2'b10:   w_level_d = r_level + 1'b1;
            2'b01:   w_level_d = r_level - 1'b1;
            default: w_level_d = r_level;
         endcase
      end
      // Ready is a function of next state only, so it never depends
      // combinationally on I_VALID or Z_READY at the ports.
      w_ready_d = (w_level_d < LW'(DEPTH));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_ready  <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_d;
         r_wr_ptr <= w_wr_ptr_d;
         r_level  <= w_level_d;
         r_ready  <= w_ready_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge CLK) begin
      if (w_push && !FLUSH) r_mem[r_wr_ptr] <= I;
   end

   assign I_READY = r_ready;
   assign Z_VALID = w_zvalid;
   assign Z       = w_zvalid ? r_mem[r_rd_ptr] : '0;
   assign LEVEL   = r_level;

endmodule
